// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared constants for the LCD text sequencer: state codes, HD44780 command
// bytes and the DDRAM start address of each display line.
// No ports (package).
// -----------------------------------------------------------------------------
package lcd_pkg;

   // State codes (code 5 is unused and recovers to ST_DELAY)
   localparam logic [2:0] ST_DELAY      = 3'd0;
   localparam logic [2:0] ST_FUNC_SET   = 3'd1;
   localparam logic [2:0] ST_ENTRY_MODE = 3'd2;
   localparam logic [2:0] ST_DISP_ON    = 3'd3;
   localparam logic [2:0] ST_LINE       = 3'd4;
   localparam logic [2:0] ST_UNUSED     = 3'd5;
   localparam logic [2:0] ST_HOLD       = 3'd6;
   localparam logic [2:0] ST_CLEAR      = 3'd7;

   // Command bytes (8-bit interface, 5x8 font)
   localparam logic [7:0] CMD_FUNC_2L   = 8'h38;
   localparam logic [7:0] CMD_FUNC_1L   = 8'h30;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

   // DDRAM address of column 0 for each display line
   function automatic logic [7:0] ddram_base(input logic [1:0] line_idx);
      logic [7:0] base;
      case (line_idx)
         2'd0:    base = 8'h00;
         2'd1:    base = 8'h40;
         2'd2:    base = 8'h14;
         2'd3:    base = 8'h54;
         default: base = 8'h00;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// -----------------------------------------------------------------------------
// lcd_phase_timer
// Dwell counter for one sequencer phase. Counts up from 0 to the terminal
// count t and then holds there until the owner restarts it with load.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-low reset
//   load  in   restart the count at 0 on the next edge
//   t     in   terminal count of the current phase
//   cnt   out  current dwell count
//   done  out  cnt has reached t
//   e     out  strobe window, high while 1 <= cnt <= t/2
// -----------------------------------------------------------------------------
module lcd_phase_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] t,
   output logic [CNT_W-1:0] cnt,
   output logic             done,
   output logic             e
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Dwell count: restart on load, otherwise climb and hold at t
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (cnt != t) begin
         cnt <= cnt + CNT_ONE;
      end else begin
         cnt <= cnt;
      end
   end

   assign done = (cnt == t);
   // Enable goes high one cycle after the bus settles and drops at mid-phase
   assign e    = (cnt != '0) && (cnt <= (t >> 1));

endmodule

// File: rtl/lcd_text_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_text_sequencer
// Drives an HD44780-class character LCD in 8-bit write-only mode: power-up
// delay, init commands, then frames of NUM_LINES x LINE_LEN characters read
// from an external buffer, separated by a hold phase and a clear command.
// Optional feature macro: LCD_AUTO_REFRESH_EN (HOLD also exits to CLEAR when
// its dwell expires; otherwise HOLD is left only on an update request and
// the dwell count saturates).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   upd_req    in   level request to redraw the display
//   upd_ack    out  one-cycle pulse when the request is accepted
//   char_data  in   buffer data for char_addr (same-cycle read)
//   char_addr  out  {line_idx, col-1} buffer read address
//   lcd_e      out  LCD enable strobe
//   lcd_rs     out  0 = command, 1 = data
//   lcd_rw     out  tied 0 (write only)
//   lcd_db     out  LCD data bus
//   state      out  current state code
//   cnt        out  dwell counter
//   frame_done out  one-cycle pulse after the last character of a frame
// -----------------------------------------------------------------------------
module lcd_text_sequencer
   import lcd_pkg::*;
#(
   parameter int NUM_LINES = 2,
   parameter int LINE_LEN  = 16,
   parameter int DLY_PWRUP = 70,
   parameter int DLY_CMD   = 30,
   parameter int DLY_CHAR  = 20,
   parameter int DLY_HOLD  = 400,
   parameter int DLY_CLEAR = 200,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             upd_req,
   output logic             upd_ack,
   input  logic [7:0]       char_data,
   output logic [7:0]       char_addr,
   output logic             lcd_e,
   output logic             lcd_rs,
   output logic             lcd_rw,
   output logic [7:0]       lcd_db,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cnt,
   output logic             frame_done
);

   localparam logic [5:0] LAST_COL  = 6'(LINE_LEN);
   localparam logic [1:0] LAST_LINE = 2'(NUM_LINES - 1);
   localparam logic [7:0] FUNC_CMD  = (NUM_LINES > 1) ? CMD_FUNC_2L : CMD_FUNC_1L;

   logic [1:0]       line_idx;
   logic [5:0]       col;
   logic             pending;

   logic [2:0]       state_nxt;
   logic [1:0]       line_nxt;
   logic [5:0]       col_nxt;
   logic             pending_nxt;
   logic             ack_nxt;
   logic             fd_nxt;
   logic             load;
   logic [CNT_W-1:0] t_sel;
   logic             done;
   logic             e_win;
   logic             strobe_en;

   lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .t    (t_sel),
      .cnt  (cnt),
      .done (done),
      .e    (e_win)
   );

   // Terminal count of the phase currently running
   always_comb begin
      t_sel = '0;
      case (state)
         ST_DELAY:      t_sel = CNT_W'(DLY_PWRUP);
         ST_FUNC_SET,
         ST_DISP_ON,
         ST_ENTRY_MODE: t_sel = CNT_W'(DLY_CMD);
         ST_LINE:       t_sel = CNT_W'(DLY_CHAR);
         ST_HOLD:       t_sel = CNT_W'(DLY_HOLD);
         ST_CLEAR:      t_sel = CNT_W'(DLY_CLEAR);
         default:       t_sel = '0;
      endcase
   end

   // Phase sequencing, line/column walk and update handshake
   always_comb begin
      state_nxt   = state;
      line_nxt    = line_idx;
      col_nxt     = col;
      pending_nxt = pending | upd_req;
      ack_nxt     = 1'b0;
      fd_nxt      = 1'b0;
      load        = 1'b0;
      case (state)
         ST_DELAY: begin
            if (done) begin
               state_nxt = ST_FUNC_SET;
               load      = 1'b1;
            end else begin
               state_nxt = state;
            end
         end
         ST_FUNC_SET: begin
            if (done) begin
               state_nxt = ST_DISP_ON;
               load      = 1'b1;
            end else begin
               state_nxt = state;
            end
         end
         ST_DISP_ON: begin
            if (done) begin
               state_nxt = ST_ENTRY_MODE;
               load      = 1'b1;
            end else begin
               state_nxt = state;
            end
         end
         ST_ENTRY_MODE, ST_CLEAR: begin
            if (done) begin
               state_nxt = ST_LINE;
               load      = 1'b1;
            end else begin
               state_nxt = state;
            end
         end
         ST_LINE: begin
            if (done) begin
               load = 1'b1;
               if (col == LAST_COL) begin
                  col_nxt = 6'd0;
                  if (line_idx == LAST_LINE) begin
                     line_nxt  = 2'd0;
                     state_nxt = ST_HOLD;
                     fd_nxt    = 1'b1;
                  end else begin
                     line_nxt = line_idx + 2'd1;
                  end
               end else begin
                  col_nxt = col + 6'd1;
               end
            end else begin
               col_nxt = col;
            end
         end
         ST_HOLD: begin
            // A request seen here is consumed directly rather than latched
            pending_nxt = pending;
            if (upd_req || pending) begin
               state_nxt   = ST_CLEAR;
               load        = 1'b1;
               ack_nxt     = 1'b1;
               pending_nxt = 1'b0;
            end
`ifdef LCD_AUTO_REFRESH_EN
            else if (done) begin
               state_nxt = ST_CLEAR;
               load      = 1'b1;
            end
`endif
            else begin
               state_nxt = state;
            end
         end
         default: begin
            state_nxt = ST_DELAY;
            line_nxt  = 2'd0;
            col_nxt   = 6'd0;
            load      = 1'b1;
         end
      endcase
   end

   // Bus contents for the current phase; held constant for the whole phase
   always_comb begin
      lcd_rs    = 1'b0;
      lcd_db    = 8'h00;
      char_addr = 8'h00;
      strobe_en = 1'b0;
      case (state)
         ST_FUNC_SET: begin
            lcd_db    = FUNC_CMD;
            strobe_en = 1'b1;
         end
         ST_DISP_ON: begin
            lcd_db    = CMD_DISP_ON;
            strobe_en = 1'b1;
         end
         ST_ENTRY_MODE: begin
            lcd_db    = CMD_ENTRY;
            strobe_en = 1'b1;
         end
         ST_CLEAR: begin
            lcd_db    = CMD_CLEAR;
            strobe_en = 1'b1;
         end
         ST_LINE: begin
            strobe_en = 1'b1;
            if (col == 6'd0) begin
               lcd_db = CMD_SET_DDRAM | ddram_base(line_idx);
            end else begin
               lcd_rs    = 1'b1;
               char_addr = {line_idx, col - 6'd1};
               lcd_db    = char_data;
            end
         end
         default: begin
            lcd_db = 8'h00;
         end
      endcase
   end

   assign lcd_e  = strobe_en & e_win;
   assign lcd_rw = 1'b0;

   // State, position, pending request and handshake pulses
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_DELAY;
         line_idx   <= 2'd0;
         col        <= 6'd0;
         pending    <= 1'b0;
         upd_ack    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         line_idx   <= line_nxt;
         col        <= col_nxt;
         pending    <= pending_nxt;
         upd_ack    <= ack_nxt;
         frame_done <= fd_nxt;
      end
   end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_sequencer
// Directed walk through init, frames, hold/clear handshake and a mid-frame
// reset, with a random character buffer. Expected bus contents are derived
// per phase from the display rules; a second instance with 4 lines x 20
// columns records its first frame's address bytes and sub-phase count.
// -----------------------------------------------------------------------------
module tb_lcd_text_sequencer;

   localparam int NL = 2, LL = 16;
   localparam int T_PWR = 70, T_CMD = 30, T_CHR = 20, T_HLD = 400, T_CLR = 200;

   logic        clk = 1'b0;
   logic        rst;
   logic        upd_req;
   logic        upd_ack;
   logic [7:0]  char_data, char_addr, lcd_db;
   logic        lcd_e, lcd_rs, lcd_rw, frame_done;
   logic [2:0]  state;
   logic [15:0] cnt;

   logic        upd_req4 = 1'b0;
   logic        upd_ack4, lcd_e4, lcd_rs4, lcd_rw4, frame_done4;
   logic [7:0]  char_data4, char_addr4, lcd_db4;
   logic [2:0]  state4;
   logic [15:0] cnt4;

   logic [7:0]  mem [0:255];
   int          total = 0;
   int          bad   = 0;

   logic [7:0]  addr4 [0:7];
   int          idx4 = 0;
   int          sub4 = 0;
   logic        seen4 = 1'b0;

   always #5 clk = ~clk;

   assign char_data  = mem[char_addr];
   assign char_data4 = mem[char_addr4];

   lcd_text_sequencer dut (
      .clk(clk), .rst(rst), .upd_req(upd_req), .upd_ack(upd_ack),
      .char_data(char_data), .char_addr(char_addr), .lcd_e(lcd_e),
      .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db), .state(state),
      .cnt(cnt), .frame_done(frame_done)
   );

   lcd_text_sequencer #(
      .NUM_LINES(4), .LINE_LEN(20), .DLY_PWRUP(5), .DLY_CMD(3),
      .DLY_CHAR(3), .DLY_HOLD(10), .DLY_CLEAR(4), .CNT_W(16)
   ) dut4 (
      .clk(clk), .rst(rst), .upd_req(upd_req4), .upd_ack(upd_ack4),
      .char_data(char_data4), .char_addr(char_addr4), .lcd_e(lcd_e4),
      .lcd_rs(lcd_rs4), .lcd_rw(lcd_rw4), .lcd_db(lcd_db4), .state(state4),
      .cnt(cnt4), .frame_done(frame_done4)
   );

   // Record the 4-line instance's first frame: address bytes and sub-phases
   always @(negedge clk) begin
      if (rst && !seen4) begin
         if (state4 == 3'd4 && cnt4 == 16'd0) begin
            sub4 <= sub4 + 1;
            if (!lcd_rs4 && idx4 < 8) begin
               addr4[idx4] <= lcd_db4;
               idx4        <= idx4 + 1;
            end
         end
         if (frame_done4) seen4 <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One phase of ncyc cycles; caller sits at the negedge of its first cycle
   task automatic run_phase(input logic [2:0] st, input int ncyc, input int t,
                            input bit strobe, input bit rs, input logic [7:0] db,
                            input logic [7:0] addr, input int req_at,
                            input bit ack0, input bit fd0, input int sat);
      int c;
      for (int k = 0; k < ncyc; k++) begin
         c = (sat >= 0 && k > sat) ? sat : k;
         chk("state",      32'(state),      32'(st));
         chk("cnt",        32'(cnt),        32'(c));
         chk("lcd_e",      32'(lcd_e),      32'(strobe && k >= 1 && k <= t / 2));
         chk("lcd_rs",     32'(lcd_rs),     32'(rs));
         chk("lcd_rw",     32'(lcd_rw),     32'(0));
         chk("lcd_db",     32'(lcd_db),     32'(db));
         chk("char_addr",  32'(char_addr),  32'(addr));
         chk("upd_ack",    32'(upd_ack),    32'(ack0 && k == 0));
         chk("frame_done", 32'(frame_done), 32'(fd0 && k == 0));
         upd_req = (k == req_at);
         @(negedge clk);
      end
      upd_req = 1'b0;
   endtask

   task automatic run_init(input int req_disp);
      run_phase(3'd0, T_PWR + 1, T_PWR, 1'b0, 1'b0, 8'h00, 8'h00, -1, 1'b0, 1'b0, -1);
      run_phase(3'd1, T_CMD + 1, T_CMD, 1'b1, 1'b0, 8'h38, 8'h00, -1, 1'b0, 1'b0, -1);
      run_phase(3'd3, T_CMD + 1, T_CMD, 1'b1, 1'b0, 8'h0C, 8'h00, req_disp, 1'b0, 1'b0, -1);
      run_phase(3'd2, T_CMD + 1, T_CMD, 1'b1, 1'b0, 8'h06, 8'h00, -1, 1'b0, 1'b0, -1);
   endtask

   // Walk all (line, col) sub-phases, returning early at (stop_line, stop_col)
   task automatic run_frame(input int stop_line, input int stop_col);
      logic [7:0] base [0:3];
      logic [7:0] a;
      base[0] = 8'h00; base[1] = 8'h40; base[2] = 8'h14; base[3] = 8'h54;
      for (int l = 0; l < NL; l++) begin
         for (int c = 0; c <= LL; c++) begin
            if (l == stop_line && c == stop_col) return;
            if (c == 0) begin
               run_phase(3'd4, T_CHR + 1, T_CHR, 1'b1, 1'b0, 8'h80 | base[l], 8'h00,
                         -1, 1'b0, 1'b0, -1);
            end else begin
               a = {l[1:0], 6'(c - 1)};
               run_phase(3'd4, T_CHR + 1, T_CHR, 1'b1, 1'b1, mem[a], a,
                         -1, 1'b0, 1'b0, -1);
            end
         end
      end
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(32, 126));
   endtask

   initial begin
      logic [7:0] exp4 [0:3];
      logic [7:0] a;
      exp4[0] = 8'h80; exp4[1] = 8'hC0; exp4[2] = 8'h94; exp4[3] = 8'hD4;
      rst     = 1'b0;
      upd_req = 1'b0;
      fill_mem();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state",  32'(state),      32'(0));
      chk("rst_cnt",    32'(cnt),        32'(0));
      chk("rst_e",      32'(lcd_e),      32'(0));
      chk("rst_rs",     32'(lcd_rs),     32'(0));
      chk("rst_db",     32'(lcd_db),     32'(0));
      chk("rst_addr",   32'(char_addr),  32'(0));
      chk("rst_ack",    32'(upd_ack),    32'(0));
      chk("rst_fd",     32'(frame_done), 32'(0));
      rst = 1'b1;

      // Init with a request during DISP_ON: held until the first HOLD
      run_init(5);
      run_frame(-1, -1);
      run_phase(3'd6, 1, T_HLD, 1'b0, 1'b0, 8'h00, 8'h00, -1, 1'b0, 1'b1, -1);
      fill_mem();
      run_phase(3'd7, T_CLR + 1, T_CLR, 1'b1, 1'b0, 8'h01, 8'h00, -1, 1'b1, 1'b0, -1);
      run_frame(-1, -1);
`ifdef LCD_AUTO_REFRESH_EN
      run_phase(3'd6, T_HLD + 1, T_HLD, 1'b0, 1'b0, 8'h00, 8'h00, -1, 1'b0, 1'b1, -1);
      run_phase(3'd7, T_CLR + 1, T_CLR, 1'b1, 1'b0, 8'h01, 8'h00, -1, 1'b0, 1'b0, -1);
      run_frame(-1, -1);
      // Request coinciding with the hold terminal count
      run_phase(3'd6, T_HLD + 1, T_HLD, 1'b0, 1'b0, 8'h00, 8'h00, T_HLD, 1'b0, 1'b1, -1);
`else
      // Hold saturates, then a late request ends it
      run_phase(3'd6, 2000, T_HLD, 1'b0, 1'b0, 8'h00, 8'h00, 1999, 1'b0, 1'b1, T_HLD);
`endif
      run_phase(3'd7, T_CLR + 1, T_CLR, 1'b1, 1'b0, 8'h01, 8'h00, -1, 1'b1, 1'b0, -1);

      // Reset in the middle of line 1, column 5, at cnt 7
      run_frame(1, 5);
      a = 8'h44;
      run_phase(3'd4, 7, T_CHR, 1'b1, 1'b1, mem[a], a, -1, 1'b0, 1'b0, -1);
      chk("mid_cnt",   32'(cnt),   32'(7));
      chk("mid_state", 32'(state), 32'(4));
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_state", 32'(state),     32'(0));
      chk("mrst_cnt",   32'(cnt),       32'(0));
      chk("mrst_e",     32'(lcd_e),     32'(0));
      chk("mrst_addr",  32'(char_addr), 32'(0));
      rst = 1'b1;
      run_init(-1);
      run_frame(-1, -1);
      run_phase(3'd6, 1, T_HLD, 1'b0, 1'b0, 8'h00, 8'h00, -1, 1'b0, 1'b1, -1);

      // Four-line geometry results
      chk("g4_frame_seen", 32'(seen4), 32'(1));
      chk("g4_subphases",  32'(sub4),  32'(84));
      chk("g4_addr_count", 32'(idx4),  32'(4));
      for (int i = 0; i < 4; i++) chk("g4_addr_byte", 32'(addr4[i]), 32'(exp4[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
